// File: rtl/game_pkg.sv
// Shared definitions for the mosquito kill/respawn return path.
// Slot-state encoding, default frame counts and counter width.
package game_pkg;

    typedef enum logic [1:0] {
        SlotAlive   = 2'd0,
        SlotDying   = 2'd1,
        SlotDead    = 2'd2,
        SlotRespawn = 2'd3
    } slot_state_e;

    localparam int unsigned DYING_FRAMES_DEF   = 8;
    localparam int unsigned RESPAWN_FRAMES_DEF = 60;
    localparam int unsigned CNT_W_DEF          = 8;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mosquito_slot_lifecycle.sv
// Single-slot kill / dying / dead / respawn lifecycle with a frame counter.
// hit is expected to be pre-qualified with the slot's alive flag.
module mosquito_slot_lifecycle
    import game_pkg::*;
#(
    parameter int unsigned DYING_FRAMES   = DYING_FRAMES_DEF,
    parameter int unsigned RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic hit,
    input  logic ack,
    output logic kill,
    output logic dying,
    output logic req
);

    localparam logic [CNT_W-1:0] DYING_LOAD   = CNT_W'(DYING_FRAMES - 1);
    localparam logic [CNT_W-1:0] RESPAWN_LOAD = CNT_W'(RESPAWN_FRAMES - 1);

    slot_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             kill_q, kill_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SlotAlive;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill_d  = 1'b0;
        unique case (state_q)
            SlotAlive: begin
                // A load on entry wins over a coincident frame_tick.
                if (hit) begin
                    kill_d  = 1'b1;
                    state_d = SlotDying;
                    cnt_d   = DYING_LOAD;
                end
            end
            SlotDying: begin
                if (frame_tick) begin
                    if (cnt_q == '0) begin
                        state_d = SlotDead;
                        cnt_d   = RESPAWN_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            SlotDead: begin
                if (frame_tick) begin
                    if (cnt_q == '0) begin
                        state_d = SlotRespawn;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            SlotRespawn: begin
                if (ack) begin
                    state_d = SlotAlive;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SlotAlive;
                cnt_d   = '0;
            end
        endcase
    end

    assign kill  = kill_q;
    assign dying = (state_q == SlotDying);
    assign req   = (state_q == SlotRespawn);

endmodule

// File: rtl/enemy_hit_to_mosquito_router.sv
// Routes collision hits (enemy slot i -> mosquito slot i) through per-slot lifecycles,
// and produces the per-cycle score increment and a saturating kill total.
module enemy_hit_to_mosquito_router
    import game_pkg::*;
#(
    parameter int unsigned N_MOSQ         = 2,
    parameter int unsigned DYING_FRAMES   = DYING_FRAMES_DEF,
    parameter int unsigned RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic [N_MOSQ-1:0] enemy_hit_flat,
    input  logic [N_MOSQ-1:0] mosquito_alive_flat,
    input  logic [N_MOSQ-1:0] respawn_ack,
    output logic [N_MOSQ-1:0] mosquito_kill,
    output logic [N_MOSQ-1:0] mosquito_dying,
    output logic [N_MOSQ-1:0] respawn_req,
    output logic [3:0]        score_inc,
    output logic [CNT_W-1:0]  kill_count
);

    localparam int unsigned     SUM_W   = CNT_W + 4;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [N_MOSQ-1:0] qualified_hit;
    logic [CNT_W-1:0]  kill_count_q, kill_count_d;
    logic [SUM_W-1:0]  count_sum;

    assign qualified_hit = enemy_hit_flat & mosquito_alive_flat;

    for (genvar i = 0; i < N_MOSQ; i++) begin : g_slot
        mosquito_slot_lifecycle #(
            .DYING_FRAMES   (DYING_FRAMES),
            .RESPAWN_FRAMES (RESPAWN_FRAMES),
            .CNT_W          (CNT_W)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .frame_tick (frame_tick),
            .hit        (qualified_hit[i]),
            .ack        (respawn_ack[i]),
            .kill       (mosquito_kill[i]),
            .dying      (mosquito_dying[i]),
            .req        (respawn_req[i])
        );
    end

    // Decoded from the registered kill bits, so it stays aligned with mosquito_kill.
    assign score_inc = popcount8(8'(mosquito_kill));

    always_comb begin
        count_sum    = SUM_W'(kill_count_q) + SUM_W'(score_inc);
        kill_count_d = (count_sum > CNT_MAX) ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kill_count_q <= '0;
        end else begin
            kill_count_q <= kill_count_d;
        end
    end

    assign kill_count = kill_count_q;

endmodule

// File: tb/tb_enemy_hit_to_mosquito_router.sv
// Bench for enemy_hit_to_mosquito_router: fixed vector table, directed lifecycle
// sequences and randomized traffic, all checked against an elapsed-tick model.
module tb_enemy_hit_to_mosquito_router;

    localparam int DYING   = 8;
    localparam int RESPAWN = 60;
    localparam int CMAX    = 255;

    logic       clk = 1'b0;
    logic       reset, frame_tick;
    logic [1:0] enemy_hit_flat, mosquito_alive_flat, respawn_ack;
    logic [1:0] mosquito_kill, mosquito_dying, respawn_req;
    logic [3:0] score_inc;
    logic [7:0] kill_count;

    int vectors     = 0;
    int miscompares = 0;

    // Model: a killed slot counts frame ticks since its kill; its phase follows from that.
    bit         killed [2];
    int         ticks  [2];
    logic [1:0] m_kill;
    int         m_score, m_count;

    enemy_hit_to_mosquito_router #(
        .N_MOSQ         (2),
        .DYING_FRAMES   (DYING),
        .RESPAWN_FRAMES (RESPAWN),
        .CNT_W          (8)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .frame_tick          (frame_tick),
        .enemy_hit_flat      (enemy_hit_flat),
        .mosquito_alive_flat (mosquito_alive_flat),
        .respawn_ack         (respawn_ack),
        .mosquito_kill       (mosquito_kill),
        .mosquito_dying      (mosquito_dying),
        .respawn_req         (respawn_req),
        .score_inc           (score_inc),
        .kill_count          (kill_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_dying();
        logic [1:0] d;
        for (int i = 0; i < 2; i++) d[i] = killed[i] && ticks[i] < DYING;
        return d;
    endfunction

    function automatic logic [1:0] exp_req();
        logic [1:0] r;
        for (int i = 0; i < 2; i++) r[i] = killed[i] && ticks[i] >= DYING + RESPAWN;
        return r;
    endfunction

    task automatic model_edge();
        int nc;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                killed[i] = 0;
                ticks[i]  = 0;
            end
            m_kill  = '0;
            m_score = 0;
            m_count = 0;
        end else begin
            nc = m_count + m_score;
            if (nc > CMAX) nc = CMAX;
            m_kill = '0;
            for (int i = 0; i < 2; i++) begin
                if (!killed[i]) begin
                    if (enemy_hit_flat[i] && mosquito_alive_flat[i]) begin
                        killed[i] = 1;
                        ticks[i]  = 0;
                        m_kill[i] = 1'b1;
                    end
                end else if (ticks[i] >= DYING + RESPAWN) begin
                    if (respawn_ack[i]) killed[i] = 0;
                end else if (frame_tick) begin
                    ticks[i]++;
                end
            end
            m_score = $countones(m_kill);
            m_count = nc;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("kill", 32'(mosquito_kill), 32'(m_kill));
        check("dying", 32'(mosquito_dying), 32'(exp_dying()));
        check("req", 32'(respawn_req), 32'(exp_req()));
        check("score_inc", 32'(score_inc), 32'(m_score));
        check("kill_count", 32'(kill_count), 32'(m_count));
    endtask

    task automatic idle_inputs();
        reset = 0; frame_tick = 0; enemy_hit_flat = '0; respawn_ack = '0;
        mosquito_alive_flat = 2'b11;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    typedef struct {
        logic       rst;
        logic       tick;
        logic [1:0] hit, alive, ack;
        logic [1:0] kill, dying, req;
        logic [3:0] score;
        logic [7:0] count;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int n, dying_len, got_req;

        tbl[0] = '{1, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 8'd0}; // reset
        tbl[1] = '{0, 0, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 4'd1, 8'd0}; // kill slot 0
        tbl[2] = '{0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 4'd0, 8'd1};
        tbl[3] = '{0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 4'd0, 8'd1}; // slot 1 not alive
        tbl[4] = '{0, 0, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 4'd0, 8'd1}; // hit while dying
        tbl[5] = '{0, 0, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 4'd0, 8'd1}; // ack slot 1 alive
        tbl[6] = '{0, 1, 2'b10, 2'b10, 2'b00, 2'b10, 2'b11, 2'b00, 4'd1, 8'd1};
        tbl[7] = '{0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 4'd0, 8'd2};

        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            killed[i] = 0;
            ticks[i]  = 0;
        end
        m_kill = '0; m_score = 0; m_count = 0;

        for (int v = 0; v < 8; v++) begin
            reset = tbl[v].rst; frame_tick = tbl[v].tick; enemy_hit_flat = tbl[v].hit;
            mosquito_alive_flat = tbl[v].alive; respawn_ack = tbl[v].ack;
            step();
            check("tbl_kill", 32'(mosquito_kill), 32'(tbl[v].kill));
            check("tbl_dying", 32'(mosquito_dying), 32'(tbl[v].dying));
            check("tbl_req", 32'(respawn_req), 32'(tbl[v].req));
            check("tbl_score", 32'(score_inc), 32'(tbl[v].score));
            check("tbl_count", 32'(kill_count), 32'(tbl[v].count));
        end

        // Hit coinciding with a frame tick, then walk the whole lifecycle of slot 0.
        do_reset();
        enemy_hit_flat = 2'b01; frame_tick = 1;
        step();
        check("seq_kill_latency", 32'(mosquito_kill), 32'd1);
        idle_inputs();
        step();
        check("seq_kill_one_cycle", 32'(mosquito_kill), 32'd0);
        check("seq_count_after", 32'(kill_count), 32'd1);
        n = 0; dying_len = -1; got_req = 0;
        for (int k = 0; k < 200 && !got_req; k++) begin
            frame_tick = 1; step();
            frame_tick = 0; step();
            n++;
            if (dying_len < 0 && !mosquito_dying[0]) dying_len = n;
            if (respawn_req[0]) got_req = 1;
        end
        check("seq_dying_ticks", 32'(dying_len), 32'(DYING));
        check("seq_req_ticks", 32'(n), 32'(DYING + RESPAWN));
        for (int k = 0; k < 5; k++) begin
            frame_tick = k[0];
            step();
            check("seq_req_held", 32'(respawn_req[0]), 32'd1);
        end
        idle_inputs();
        respawn_ack = 2'b01; enemy_hit_flat = 2'b01;
        step();
        check("seq_req_drop", 32'(respawn_req[0]), 32'd0);
        check("seq_hit_in_ack", 32'(mosquito_kill), 32'd0);
        idle_inputs();
        enemy_hit_flat = 2'b01;
        step();
        check("seq_rekill", 32'(mosquito_kill), 32'd1);

        // Simultaneous hits.
        do_reset();
        enemy_hit_flat = 2'b11;
        step();
        check("sim_kill", 32'(mosquito_kill), 32'd3);
        check("sim_score", 32'(score_inc), 32'd2);
        idle_inputs();
        step();
        check("sim_count", 32'(kill_count), 32'd2);

        // Saturation: 300 kills, both slots per round.
        do_reset();
        for (int r = 0; r < 150; r++) begin
            idle_inputs(); enemy_hit_flat = 2'b11;
            step();
            idle_inputs(); frame_tick = 1;
            for (int t = 0; t < DYING + RESPAWN; t++) step();
            idle_inputs(); respawn_ack = 2'b11;
            step();
        end
        idle_inputs();
        step();
        check("sat_count", 32'(kill_count), 32'd255);

        // Reset while slot 1 is DEAD.
        idle_inputs(); enemy_hit_flat = 2'b10;
        step();
        idle_inputs(); frame_tick = 1;
        for (int t = 0; t < DYING + 3; t++) step();
        idle_inputs(); reset = 1; enemy_hit_flat = 2'b11;
        step();
        check("rst_kill", 32'(mosquito_kill), 32'd0);
        check("rst_dying", 32'(mosquito_dying), 32'd0);
        check("rst_req", 32'(respawn_req), 32'd0);
        check("rst_score", 32'(score_inc), 32'd0);
        check("rst_count", 32'(kill_count), 32'd0);
        idle_inputs(); enemy_hit_flat = 2'b10;
        step();
        check("rst_slot1_alive", 32'(mosquito_kill), 32'd2);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset               = ($urandom_range(0, 599) == 0);
            frame_tick          = $urandom_range(0, 1);
            mosquito_alive_flat = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                enemy_hit_flat[i] = ($urandom_range(0, 3) == 0);
                respawn_ack[i]    = ($urandom_range(0, 3) == 0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/enemy_hit_to_mosquito_router.md
Name: enemy_hit_to_mosquito_router

Overview:
- Return path from the collision stage to the mosquito controller.
- The collision unit reports hits in enemy-slot index space. This block maps enemy slot i to mosquito slot i and runs a per-slot kill / dying / respawn lifecycle.
- Emits kill pulses, dying flags, a respawn request/acknowledge handshake and a score increment.
- Sits between the collision detector (upstream) and the mosquito movement controller and score logic (downstream).

Parameters:
- N_MOSQ, 2, number of mosquito/enemy slots (1..8).
- DYING_FRAMES, 8, frames a slot spends in DYING (1..255).
- RESPAWN_FRAMES, 60, frames a slot spends in DEAD before requesting respawn (1..255).
- CNT_W, 8, width of the per-slot frame counter and of kill_count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- enemy_hit_flat  in  N_MOSQ  per-enemy-slot hit pulse from the collision unit
- mosquito_alive_flat  in  N_MOSQ  current alive flags from the mosquito controller
- respawn_ack  in  N_MOSQ  controller accepted the respawn for slot i
- mosquito_kill  out  N_MOSQ  one-cycle kill pulse per slot
- mosquito_dying  out  N_MOSQ  high while slot is in DYING (drives death sprite)
- respawn_req  out  N_MOSQ  level request, held until acknowledged
- score_inc  out  4  number of kills registered this cycle (pulse, 0 otherwise)
- kill_count  out  CNT_W  saturating total kills since reset

Behaviour:
- Single clock domain. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - all slots go to ALIVE with counter 0;
  - mosquito_kill, mosquito_dying, respawn_req = 0;
  - score_inc = 0 and kill_count = 0.
  - Reset asserted mid-operation aborts any DYING/DEAD/RESPAWN state; no kill or score pulse is produced that cycle.
- Per-slot FSM states: ALIVE, DYING, DEAD, RESPAWN.
- ALIVE:
  - A qualified hit is enemy_hit_flat[i] & mosquito_alive_flat[i].
  - On a qualified hit, the next edge registers mosquito_kill[i]=1 for exactly one cycle, moves the slot to DYING and loads counter = DYING_FRAMES-1. Latency from hit to kill pulse is 1 cycle.
  - A hit while mosquito_alive_flat[i]=0 is ignored.
- DYING:
  - mosquito_dying[i]=1.
  - On frame_tick: if counter==0, go to DEAD and load RESPAWN_FRAMES-1; else decrement the counter.
  - Hits are ignored.
- DEAD:
  - On frame_tick: if counter==0, go to RESPAWN; else decrement.
  - Hits are ignored.
- RESPAWN:
  - respawn_req[i]=1, held regardless of frame_tick.
  - respawn_ack[i]=1 returns the slot to ALIVE on the next edge; respawn_req drops that same edge.
  - A hit in the ack cycle is ignored.
- respawn_ack[i] in any state other than RESPAWN is ignored.
- Counters only change on frame_tick, except when loaded on a state entry. A hit and a frame_tick in the same cycle: the hit is processed and the counter loads; the tick is not applied to the freshly loaded value.
- score_inc:
  - Registered popcount of the qualified hits taken while ALIVE in the same cycle, aligned with mosquito_kill.
  - Simultaneous hits on several slots produce several kill bits plus one score_inc equal to their count.
- kill_count:
  - Increments by score_inc in the cycle after score_inc is registered.
  - Saturates at 2^CNT_W-1; it never wraps.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package (game_pkg) holds:
  - the slot-state encoding (ALIVE=2'd0, DYING=2'd1, DEAD=2'd2, RESPAWN=2'd3);
  - default DYING_FRAMES / RESPAWN_FRAMES constants;
  - CNT_W.
- One natural sub-module, mosquito_slot_lifecycle: a single-slot FSM plus counter with ports clk, reset, frame_tick, hit, ack, kill, dying, req. It is instantiated N_MOSQ times with a generate loop.
- The top level adds the popcount for score_inc and the saturating kill_count.

Test Plan:
- Kill latency and dying length:
  - Stimulus: reset, then hit slot 0 with alive=2'b11, DYING_FRAMES=8.
  - Required: mosquito_kill=2'b01 for 1 cycle, 1 cycle after the hit; score_inc=1 that cycle; kill_count=1 one cycle later; mosquito_dying[0] high for exactly 8 frame_ticks.
- Full lifecycle:
  - Stimulus: after DYING, slot 0 waits out RESPAWN_FRAMES=60 ticks.
  - Required: respawn_req[0] rises after the 60th tick and holds for 5 cycles with no ack; ack pulse → req low and slot ALIVE next edge.
  - Required: a hit 1 cycle later produces a new kill.
- Simultaneous hits:
  - Stimulus: enemy_hit_flat=2'b11 in the same cycle, alive=2'b11.
  - Required: mosquito_kill=2'b11, score_inc=2, kill_count +2.
- Ignored events (each must produce no kill pulse and no state change):
  - hit with alive[1]=0;
  - hit on slot 0 while DYING;
  - respawn_ack=2'b01 while slot 0 is ALIVE.
- Saturation and reset:
  - Stimulus: with CNT_W=8, drive 300 kills (slots respawned via immediate ack).
  - Required: kill_count stops at 255.
  - Then assert reset while slot 1 is DEAD: all outputs are 0 next edge and slot 1 is ALIVE.
- Hit coinciding with frame_tick:
  - Stimulus: hit and frame_tick in the same cycle.
  - Required: dying lasts the full DYING_FRAMES ticks, not one fewer.
